axicb_rr_arbiter_prio: RTL and testbench
========================================

AXICB_RR_ARBITER_PRIO -- requirements
Module: axicb_rr_arbiter_prio

Interface
REQ-001 SHALL have parameter REQ_NB, default 4; number of requesters, any integer >= 2.
REQ-002 SHALL have parameter PRIO_W, default 2; width of the per-requester priority field, giving 2**PRIO_W levels.
REQ-003 SHALL have port aclk, input, 1 bit; clock, all logic on rising edge.
REQ-004 SHALL have port aresetn, input, 1 bit; reset, asynchronous, active-low.
REQ-005 SHALL have port srst, input, 1 bit; synchronous reset, active-high.
REQ-006 SHALL have port en, input, 1 bit; arbitration enable.
REQ-007 SHALL have port req, input, REQ_NB bits; request vector.
REQ-008 SHALL have port prio, input, REQ_NB*PRIO_W bits; priority of requester i in bits [i*PRIO_W +: PRIO_W], where a higher value is more urgent.
REQ-009 SHALL have port done, input, 1 bit; pulse releasing the current grant.
REQ-010 SHALL have port grant, output, REQ_NB bits; registered one-hot or zero grant.
REQ-011 SHALL have port grant_id, output, $clog2(REQ_NB) bits; binary index of the granted requester, 0 when no grant.
REQ-012 SHALL have port busy, output, 1 bit; high while a grant is held.

Function
REQ-013 SHALL implement a two-state FSM: IDLE (busy=0, grant=0) and LOCKED (busy=1, grant one-hot).
REQ-014 SHALL define the active level as the highest prio value among requesters whose req bit is set; only requesters at the active level are candidates.
REQ-015 SHALL keep one REQ_NB-bit mask per priority level; all masks reset to all-ones.
REQ-016 SHALL select the lowest-index candidate within (active-level mask & candidates); if that set is empty, the lowest-index candidate SHALL be selected.
REQ-017 On a selection of index i at level L, SHALL set mask_L to ones at bits above i (i = REQ_NB-1 gives all-ones); masks of other levels SHALL remain unchanged.
REQ-018 IDLE with en=1 and |req=1 SHALL load grant and grant_id at the next edge, move to LOCKED and update the mask. Latency is 1 cycle.
REQ-019 IDLE with en=0 or req=0 SHALL hold the state; masks SHALL not change.
REQ-020 LOCKED SHALL hold grant and grant_id stable until done=1, regardless of req, prio or en changes, including the granted request dropping.
REQ-021 LOCKED with done=1, en=1 and |req=1 SHALL re-arbitrate in the same cycle using the current masks and load the new grant at the next edge with no idle bubble.
- The releasing requester is eligible and is chosen only by the REQ-016 rules.
REQ-022 LOCKED with done=1 and (en=0 or req=0) SHALL return to IDLE with grant=0 at the next edge.
REQ-023 done in IDLE SHALL be ignored.
REQ-024 The selection logic SHALL be generic in REQ_NB and PRIO_W with no fixed-width case lists.

Reset
REQ-025 aresetn low SHALL immediately force IDLE, grant=0, grant_id=0, busy=0 and all masks to all-ones, including mid-LOCKED.
REQ-026 srst high at an edge SHALL produce the same state as REQ-025 and SHALL take precedence over done and req.
REQ-027 After reset release, the first arbitration SHALL follow REQ-016 with all-ones masks.

Verification
REQ-028 REQ_NB=4, prio all 0, req=1111, done one cycle after each grant -> grants 0001, 0010, 0100, 1000, 0001 back-to-back with busy continuously 1.
REQ-029 req=1101, prio all 0 -> grants 0001, 0100, 1000, 0001.
REQ-030 req=1111, prio of req2=2 and all others 0 -> 0100 repeated on each done; then drop req2 -> 0001, 0010 (level-0 mask still all-ones).
REQ-031 Lock: grant=0010, req drops to 0000 and no done for 5 cycles -> grant stays 0010 and busy=1; done -> grant=0000 and busy=0 at the next edge.
REQ-032 Reset mid-grant: LOCKED with grant=0100, pulse aresetn low -> grant=0000 immediately; after release with req=1111 -> grant 0001; repeat the sequence using srst.
REQ-033 REQ_NB=8, PRIO_W=1, req=10000000 -> grant_id=7; then req=11111111 -> grant 00000001 (mask wrapped to all-ones).

Source files
------------

// File: rtl/axicb_rr_arbiter_prio_if.sv
// Request/grant bundle between requesters and the priority round-robin arbiter.
// Latency: n/a (wires only).
// Backpressure: none; grants are held until the requester side pulses done.
interface axicb_rr_arbiter_prio_if #(
  parameter int REQ_NB = 4,
  parameter int PRIO_W = 2
);
  localparam int ID_W = $clog2(REQ_NB);

  logic                     en;
  logic [REQ_NB-1:0]        req;
  logic [REQ_NB*PRIO_W-1:0] prio;
  logic                     done;
  logic [REQ_NB-1:0]        grant;
  logic [ID_W-1:0]          grant_id;
  logic                     busy;

  // Requester side: drives requests and releases, observes the grant.
  modport master (
    output en, req, prio, done,
    input  grant, grant_id, busy
  );

  // Arbiter side.
  modport slave (
    input  en, req, prio, done,
    output grant, grant_id, busy
  );
endinterface

// File: rtl/axicb_rr_arbiter_prio.sv
// Priority-level round-robin arbiter with a held (locked) grant.
// Latency: 1 cycle from request (or done) to registered grant.
// Backpressure: a grant is held until done; re-arbitration on done has no bubble.
module axicb_rr_arbiter_prio #(
  parameter int REQ_NB = 4,
  parameter int PRIO_W = 2
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  srst,
  axicb_rr_arbiter_prio_if.slave arb
);
  localparam int ID_W   = $clog2(REQ_NB);
  localparam int LVL_NB = 2 ** PRIO_W;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e              state_q, state_d;
  logic [REQ_NB-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [REQ_NB-1:0]   mask_q [LVL_NB];
  logic [REQ_NB-1:0]   mask_d [LVL_NB];

  logic [PRIO_W-1:0]   lvl;
  logic [REQ_NB-1:0]   cand;
  logic [REQ_NB-1:0]   masked;
  logic [ID_W-1:0]     sel;
  logic [REQ_NB-1:0]   sel_mask;
  logic                found;
  logic                do_arb;

  // Pick the active level, its candidates, the round-robin winner and the mask it leaves behind.
  always_comb begin
    lvl = '0;
    for (int i = 0; i < REQ_NB; i++) begin
      if (arb.req[i] && (arb.prio[i*PRIO_W +: PRIO_W] > lvl)) begin
        lvl = arb.prio[i*PRIO_W +: PRIO_W];
      end
    end

    cand = '0;
    for (int i = 0; i < REQ_NB; i++) begin
      cand[i] = arb.req[i] && (arb.prio[i*PRIO_W +: PRIO_W] == lvl);
    end
    masked = cand & mask_q[lvl];

    // Masked candidates win first; if the mask has passed all of them, wrap to the lowest one.
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < REQ_NB; i++) begin
      if (masked[i] && !found) begin
        sel   = ID_W'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < REQ_NB; i++) begin
      if (cand[i] && !found) begin
        sel   = ID_W'(i);
        found = 1'b1;
      end
    end

    // Only indices above the winner stay eligible; winning the top index reopens everyone.
    sel_mask = '0;
    for (int j = 0; j < REQ_NB; j++) begin
      sel_mask[j] = (j > int'(sel));
    end
    if (sel == ID_W'(REQ_NB - 1)) begin
      sel_mask = '1;
    end
  end

  // Next-state: arbitrate from IDLE or on release, otherwise hold the lock or drop to IDLE.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    mask_d  = mask_q;
    do_arb  = arb.en && (|arb.req) && ((state_q == IDLE) || arb.done);

    if (do_arb) begin
      state_d     = LOCKED;
      grant_d     = REQ_NB'(1) << sel;
      id_d        = sel;
      mask_d[lvl] = sel_mask;
    end else if ((state_q == LOCKED) && arb.done) begin
      state_d = IDLE;
      grant_d = '0;
      id_d    = '0;
    end
  end

  // State, grant and per-level masks; both resets restore the power-up picture.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      id_q    <= '0;
      for (int l = 0; l < LVL_NB; l++) mask_q[l] <= '1;
    end else if (srst) begin
      state_q <= IDLE;
      grant_q <= '0;
      id_q    <= '0;
      for (int l = 0; l < LVL_NB; l++) mask_q[l] <= '1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      mask_q  <= mask_d;
    end
  end

  assign arb.grant    = grant_q;
  assign arb.grant_id = id_q;
  assign arb.busy     = (state_q == LOCKED);

endmodule

// File: tb/tb_axicb_rr_arbiter_prio.sv
// Bench for the priority round-robin arbiter: directed scenarios plus random traffic.
// A pointer-per-level reference model is compared against the 4-requester DUT every cycle.
// An 8-requester, 1-bit-priority instance checks wrap-around at the widest index.
module tb_axicb_rr_arbiter_prio;
  logic aclk = 1'b0;
  logic aresetn;
  logic srst;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 aclk = ~aclk;

  axicb_rr_arbiter_prio_if #(.REQ_NB(4), .PRIO_W(2)) if4 ();
  axicb_rr_arbiter_prio_if #(.REQ_NB(8), .PRIO_W(1)) if8 ();

  axicb_rr_arbiter_prio #(.REQ_NB(4), .PRIO_W(2)) dut4 (
    .aclk    (aclk),
    .aresetn (aresetn),
    .srst    (srst),
    .arb     (if4)
  );

  axicb_rr_arbiter_prio #(.REQ_NB(8), .PRIO_W(1)) dut8 (
    .aclk    (aclk),
    .aresetn (aresetn),
    .srst    (srst),
    .arb     (if8)
  );

  // Reference model: per level, remember the last index granted there (-1 = nobody yet /
  // wrapped). The winner is the first active-level requester above that index, else the first.
  int m_last [4] = '{-1, -1, -1, -1};
  bit m_busy     = 1'b0;
  int m_id       = 0;

  function automatic int prio4(input int i);
    logic [1:0] p;
    p = if4.prio[i*2 +: 2];
    return int'(p);
  endfunction

  always @(posedge aclk or negedge aresetn) begin : model
    int lvl;
    int sel;
    if (!aresetn || srst) begin
      for (int l = 0; l < 4; l++) m_last[l] = -1;
      m_busy = 1'b0;
      m_id   = 0;
    end else if (!m_busy || if4.done) begin
      if (if4.en && (if4.req != 4'b0)) begin
        lvl = 0;
        for (int i = 0; i < 4; i++)
          if (if4.req[i] && prio4(i) > lvl) lvl = prio4(i);
        sel = -1;
        for (int i = 0; i < 4; i++)
          if (sel < 0 && if4.req[i] && prio4(i) == lvl && i > m_last[lvl]) sel = i;
        for (int i = 0; i < 4; i++)
          if (sel < 0 && if4.req[i] && prio4(i) == lvl) sel = i;
        m_busy       = 1'b1;
        m_id         = sel;
        m_last[lvl]  = (sel == 3) ? -1 : sel;
      end else begin
        m_busy = 1'b0;
        m_id   = 0;
      end
    end
  end

  // Every-cycle comparison of the 4-requester DUT against the model.
  always @(posedge aclk) begin : compare
    logic [3:0] eg;
    #1;
    if (chk_en) begin
      eg = m_busy ? (4'b0001 << m_id) : 4'b0000;
      n_tests++;
      if (if4.grant !== eg || if4.busy !== m_busy || if4.grant_id !== 2'(m_id)) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t: grant=%b busy=%b id=%0d, expected grant=%b busy=%b id=%0d",
                 $time, if4.grant, if4.busy, if4.grant_id, eg, m_busy, m_id);
      end
    end
  end

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk4(input string nm, input logic [3:0] eg, input logic eb);
    logic [1:0] eid;
    eid = '0;
    for (int i = 0; i < 4; i++) if (eg[i]) eid = 2'(i);
    n_tests++;
    if (if4.grant !== eg || if4.busy !== eb || if4.grant_id !== eid) begin
      n_fail++;
      $display("FAIL %s: grant=%b busy=%b id=%0d, expected grant=%b busy=%b id=%0d",
               nm, if4.grant, if4.busy, if4.grant_id, eg, eb, eid);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] eg, input logic [2:0] eid, input logic eb);
    n_tests++;
    if (if8.grant !== eg || if8.busy !== eb || if8.grant_id !== eid) begin
      n_fail++;
      $display("FAIL %s: grant=%b busy=%b id=%0d, expected grant=%b busy=%b id=%0d",
               nm, if8.grant, if8.busy, if8.grant_id, eg, eb, eid);
    end
  endtask

  // Async reset pulse between clock edges, checking that outputs clear without a clock.
  task automatic do_areset(input string nm);
    aresetn = 1'b0;
    #1;
    chk4(nm, 4'b0000, 1'b0);
    #1;
    aresetn = 1'b1;
  endtask

  task automatic drive4(input logic en, input logic [3:0] req, input logic [7:0] prio, input logic done);
    if4.en   = en;
    if4.req  = req;
    if4.prio = prio;
    if4.done = done;
  endtask

  initial begin
    aresetn = 1'b1;
    srst    = 1'b0;
    drive4(1'b0, 4'b0, 8'h00, 1'b0);
    if8.en = 1'b0; if8.req = '0; if8.prio = '0; if8.done = 1'b0;
    #2;
    aresetn = 1'b0;
    chk_en  = 1'b1;
    cyc();
    cyc();
    chk4("reset_state", 4'b0000, 1'b0);
    chk8("reset_state8", 8'h00, 3'd0, 1'b0);
    aresetn = 1'b1;

    // 8 requesters: top index wins, then the level mask has wrapped to all-ones.
    if8.en = 1'b1; if8.req = 8'b1000_0000;
    cyc();
    chk8("n8_top", 8'b1000_0000, 3'd7, 1'b1);
    if8.req = 8'hff; if8.done = 1'b1;
    cyc();
    chk8("n8_wrap", 8'b0000_0001, 3'd0, 1'b1);
    if8.en = 1'b0; if8.req = '0;
    cyc();
    chk8("n8_release", 8'h00, 3'd0, 1'b0);
    if8.done = 1'b0;

    // Full request, equal priority, done every cycle: rotation without bubbles.
    drive4(1'b1, 4'b1111, 8'h00, 1'b0);
    cyc(); chk4("rr_full_0", 4'b0001, 1'b1);
    if4.done = 1'b1;
    cyc(); chk4("rr_full_1", 4'b0010, 1'b1);
    cyc(); chk4("rr_full_2", 4'b0100, 1'b1);
    cyc(); chk4("rr_full_3", 4'b1000, 1'b1);
    cyc(); chk4("rr_full_4", 4'b0001, 1'b1);
    if4.req = 4'b0000;
    cyc(); chk4("rr_full_idle", 4'b0000, 1'b0);

    // Sparse request pattern skips the idle requester.
    do_areset("areset_a");
    drive4(1'b1, 4'b1101, 8'h00, 1'b0);
    cyc(); chk4("rr_1101_0", 4'b0001, 1'b1);
    if4.done = 1'b1;
    cyc(); chk4("rr_1101_1", 4'b0100, 1'b1);
    cyc(); chk4("rr_1101_2", 4'b1000, 1'b1);
    cyc(); chk4("rr_1101_3", 4'b0001, 1'b1);

    // A higher level monopolises the grant; level 0 keeps its untouched mask.
    do_areset("areset_b");
    drive4(1'b1, 4'b1111, 8'h20, 1'b0);
    cyc(); chk4("prio_hi_0", 4'b0100, 1'b1);
    if4.done = 1'b1;
    cyc(); chk4("prio_hi_1", 4'b0100, 1'b1);
    cyc(); chk4("prio_hi_2", 4'b0100, 1'b1);
    if4.req = 4'b1011;
    cyc(); chk4("prio_lo_0", 4'b0001, 1'b1);
    cyc(); chk4("prio_lo_1", 4'b0010, 1'b1);

    // Lock holds through request drop, enable drop and priority churn until done.
    do_areset("areset_c");
    drive4(1'b1, 4'b0010, 8'h00, 1'b0);
    cyc(); chk4("lock_grant", 4'b0010, 1'b1);
    for (int k = 0; k < 5; k++) begin
      drive4(k[0], 4'b0000, 8'(k * 37), 1'b0);
      cyc(); chk4("lock_hold", 4'b0010, 1'b1);
    end
    drive4(1'b1, 4'b0000, 8'h00, 1'b1);
    cyc(); chk4("lock_release", 4'b0000, 1'b0);
    cyc(); chk4("idle_done_ignored", 4'b0000, 1'b0);

    // Reset mid-grant, async then sync; masks must come back all-ones.
    if4.done = 1'b0;
    do_areset("areset_d");
    if4.req = 4'b0100;
    cyc(); chk4("mid_lock_a", 4'b0100, 1'b1);
    do_areset("areset_mid_lock");
    if4.req = 4'b1111;
    cyc(); chk4("after_areset", 4'b0001, 1'b1);
    drive4(1'b1, 4'b0100, 8'h00, 1'b1);
    cyc(); chk4("mid_lock_s", 4'b0100, 1'b1);
    srst = 1'b1;
    if4.req = 4'b1111;
    cyc(); chk4("srst_over_done", 4'b0000, 1'b0);
    srst = 1'b0;
    if4.done = 1'b0;
    cyc(); chk4("after_srst", 4'b0001, 1'b1);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if4.en   = ($urandom_range(0, 7) != 0);
      if4.req  = 4'($urandom_range(0, 15));
      if4.prio = 8'($urandom);
      if4.done = ($urandom_range(0, 2) == 0);
      srst     = ($urandom_range(0, 63) == 0);
      if (c % 400 == 399) begin
        aresetn = 1'b0;
        #2;
        aresetn = 1'b1;
      end
      cyc();
    end
    srst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
